// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the three-requester memory port arbiter.
package mem_arb_pkg;

    localparam int NUM_REQ = 3;
    localparam int SEL_W   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    // Requester index to one-hot grant vector; index 3 maps to no grant.
    function automatic logic [NUM_REQ-1:0] onehot3(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        case (idx)
            2'd0:    vec = 3'b001;
            2'd1:    vec = 3'b010;
            2'd2:    vec = 3'b100;
            default: vec = 3'b000;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick3.sv
// Combinational round-robin pick over three requesters, scanning upward
// from the requester after the last grant and wrapping past index 2.
module rr_pick3
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);

    // Priority scan with the starting point rotated by the previous winner.
    always_comb begin
        any = |req;
        case (last)
            2'd0:    idx = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    idx = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and request/response sequencer sharing one memory port
// between three requesters. All outputs come straight from flops.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_W          = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_REQ-1:0] done,
    output logic               timeout_err,
    output logic               busy,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    input  logic               mem_resp_valid
);

    // Counter value seen in the final WAIT cycle before a timeout fires.
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               timeout_err_q, timeout_err_d;
    logic               busy_q, busy_d;
    logic               mem_req_valid_q, mem_req_valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   last_q, last_d;

    logic               pick_any;
    logic [SEL_W-1:0]   pick_idx;

    rr_pick3 u_pick (
        .req  (req),
        .last (last_q),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // Next-state and registered-output decode for the IDLE/ISSUE/WAIT sequence.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can leave it unassigned and infer a latch.
        state_d         = state_q;
        gnt_d           = gnt_q;
        sel_d           = sel_q;
        done_d          = '0;
        timeout_err_d   = 1'b0;
        mem_req_valid_d = mem_req_valid_q;
        cnt_d           = cnt_q;
        last_d          = last_q;

        case (state_q)
            IDLE: begin
                gnt_d           = '0;
                mem_req_valid_d = 1'b0;
                if (pick_any) begin
                    gnt_d           = onehot3(pick_idx);
                    sel_d           = pick_idx;
                    last_d          = pick_idx;
                    mem_req_valid_d = 1'b1;
                    state_d         = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    if (mem_resp_valid) begin
                        done_d  = gnt_q;
                        gnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                mem_req_valid_d = 1'b0;
                cnt_d           = cnt_q + CNT_W'(1);
                if (mem_resp_valid) begin
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    state_d = IDLE;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    gnt_d         = '0;
                    state_d       = IDLE;
                end
            end
            default: begin
                gnt_d           = '0;
                mem_req_valid_d = 1'b0;
                state_d         = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q         <= IDLE;
            gnt_q           <= '0;
            sel_q           <= '0;
            done_q          <= '0;
            timeout_err_q   <= 1'b0;
            busy_q          <= 1'b0;
            mem_req_valid_q <= 1'b0;
            cnt_q           <= '0;
            last_q          <= 2'd2;
        end else begin
            state_q         <= state_d;
            gnt_q           <= gnt_d;
            sel_q           <= sel_d;
            done_q          <= done_d;
            timeout_err_q   <= timeout_err_d;
            busy_q          <= busy_d;
            mem_req_valid_q <= mem_req_valid_d;
            cnt_q           <= cnt_d;
            last_q          <= last_d;
        end
    end

    assign gnt           = gnt_q;
    assign sel           = sel_q;
    assign done          = done_q;
    assign timeout_err   = timeout_err_q;
    assign busy          = busy_q;
    assign mem_req_valid = mem_req_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = 3'b000;
    logic       mem_req_ready  = 1'b0;
    logic       mem_resp_valid = 1'b0;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic [2:0] done;
    logic       timeout_err;
    logic       busy;
    logic       mem_req_valid;

    mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .gnt            (gnt),
        .sel            (sel),
        .done           (done),
        .timeout_err    (timeout_err),
        .busy           (busy),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit         m_armed = 1'b0;
    bit         m_in_txn, m_accepted;
    int         m_last, m_owner, m_waited;
    logic [2:0] m_gnt, m_done;
    logic [1:0] m_sel;
    logic       m_to, m_busy, m_valid;
    logic [2:0] prev_gnt = 3'b000;
    int         grant_log[$];

    function automatic int rr_pick(input logic [2:0] r, input int last);
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (last + k) % 3;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_finish(input bit ok);
        m_in_txn = 1'b0;
        m_gnt    = 3'b000;
        m_valid  = 1'b0;
        m_done   = ok ? 3'(1 << m_owner) : 3'b000;
        m_to     = !ok;
    endtask

    // Advance the model at each edge from the inputs held across it, then
    // compare every DUT output shortly after the edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_armed = 1'b1; m_in_txn = 1'b0; m_accepted = 1'b0;
                m_last = 2; m_owner = 0; m_waited = 0;
                m_gnt = 3'b000; m_sel = 2'd0; m_done = 3'b000;
                m_to = 1'b0; m_valid = 1'b0;
            end else if (m_armed) begin
                m_done = 3'b000;
                m_to   = 1'b0;
                if (!m_in_txn) begin
                    int p;
                    p = rr_pick(req, m_last);
                    m_gnt = 3'b000;
                    if (p >= 0) begin
                        m_owner = p; m_last = p; m_in_txn = 1'b1; m_accepted = 1'b0;
                        m_gnt = 3'(1 << p); m_sel = 2'(p); m_valid = 1'b1;
                    end
                end else if (!m_accepted) begin
                    if (mem_req_ready) begin
                        if (mem_resp_valid) model_finish(1'b1);
                        else begin
                            m_accepted = 1'b1; m_waited = 0; m_valid = 1'b0;
                        end
                    end
                end else begin
                    m_waited++;
                    if (mem_resp_valid) model_finish(1'b1);
                    else if (TO != 0 && m_waited == TO) model_finish(1'b0);
                end
            end
            m_busy = m_in_txn;
            #1;
            if (m_armed) begin
                check("gnt", 32'(gnt), 32'(m_gnt));
                check("sel", 32'(sel), 32'(m_sel));
                check("done", 32'(done), 32'(m_done));
                check("timeout_err", 32'(timeout_err), 32'(m_to));
                check("busy", 32'(busy), 32'(m_busy));
                check("mem_req_valid", 32'(mem_req_valid), 32'(m_valid));
                if (gnt != 3'b000 && prev_gnt == 3'b000) grant_log.push_back(int'(sel));
                prev_gnt = gnt;
            end
        end
    end

    // Advance one edge; inputs written after this land well clear of the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 3'b000; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    int exp_fair3[5] = '{0, 1, 2, 0, 1};
    int exp_fair2[4] = '{0, 2, 0, 2};

    initial begin
        // Reset held two cycles with all requesters active.
        rst = 1'b1; req = 3'b111;
        step(); step();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_valid", 32'(mem_req_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        step();
        check("first_gnt", 32'(gnt), 32'h1);
        check("first_valid", 32'(mem_req_valid), 32'h1);
        req = 3'b000; mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
        step();
        check("first_done", 32'(done), 32'h1);
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        step();

        // Single request: ready in N+1, response in N+3, done in N+4.
        do_reset();
        req = 3'b010;
        step();
        check("single_gnt", 32'(gnt), 32'h2);
        check("single_sel", 32'(sel), 32'h1);
        check("single_valid", 32'(mem_req_valid), 32'h1);
        mem_req_ready = 1'b1;
        step();
        check("single_wait_valid", 32'(mem_req_valid), 32'h0);
        mem_req_ready = 1'b0;
        step();
        mem_resp_valid = 1'b1;
        step();
        check("single_done", 32'(done), 32'h2);
        check("single_gnt_clr", 32'(gnt), 32'h0);
        check("single_busy", 32'(busy), 32'h0);
        req = 3'b000; mem_resp_valid = 1'b0;
        step();

        // Fairness with all three requesting.
        do_reset();
        grant_log.delete();
        req = 3'b111; mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
        for (int i = 0; i < 10; i++) step();
        req = 3'b000;
        step();
        check("fair3_count", 32'(grant_log.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            check("fair3_order", (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFF_FFFF, 32'(exp_fair3[i]));

        // Fairness with requesters 0 and 2 only.
        do_reset();
        grant_log.delete();
        req = 3'b101; mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
        for (int i = 0; i < 8; i++) step();
        req = 3'b000;
        step();
        check("fair2_count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check("fair2_order", (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFF_FFFF, 32'(exp_fair2[i]));

        // Same-cycle accept and response.
        do_reset();
        req = 3'b100;
        step();
        check("same_gnt", 32'(gnt), 32'h4);
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
        step();
        check("same_done", 32'(done), 32'h4);
        check("same_busy", 32'(busy), 32'h0);
        req = 3'b000; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        step();

        // Timeout after four WAIT cycles with no response.
        do_reset();
        req = 3'b001; mem_req_ready = 1'b1;
        step();
        check("to_gnt", 32'(gnt), 32'h1);
        req = 3'b000;
        step();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("to_early", 32'(timeout_err), 32'h0);
        end
        step();
        check("to_pulse", 32'(timeout_err), 32'h1);
        check("to_done", 32'(done), 32'h0);
        check("to_gnt_clr", 32'(gnt), 32'h0);
        req = 3'b011;
        step();
        check("to_pulse_end", 32'(timeout_err), 32'h0);
        check("to_next_gnt", 32'(gnt), 32'h2);
        req = 3'b000; mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
        step();
        check("to_next_done", 32'(done), 32'h2);
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        step();

        // Reset while waiting for a response; a late response is ignored.
        do_reset();
        req = 3'b010;
        step();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step();
        check("midrst_pre_gnt", 32'(gnt), 32'h2);
        rst = 1'b1; req = 3'b000;
        step();
        check("midrst_gnt", 32'(gnt), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_done", 32'(done), 32'h0);
        rst = 1'b0; mem_resp_valid = 1'b1;
        step();
        check("midrst_late_done", 32'(done), 32'h0);
        mem_resp_valid = 1'b0;
        step();

        // Randomized traffic: first with frequent responses, then sparse ones
        // so the timeout path is exercised often.
        for (int i = 0; i < 4000; i++) begin
            step();
            req            = 3'($urandom);
            mem_req_ready  = ($urandom_range(0, 9) < 6);
            mem_resp_valid = (i < 2500) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) < 1);
            rst            = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
